// File: rtl/gpio_seq_checker.sv
// gpio_seq_checker: step-table sequence checker and stimulus transactor for caravan mprj_io benches.
// Optional build define GPIO_SEQ_TSTAMP_EN adds a per-step accept timestamp RAM with a registered read port.
module gpio_seq_checker #(
    parameter int DEPTH       = 16,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [22:0]              prog_data,
    input  logic [37:0]              mprj_io_in,
    output logic [13:0]              setbits_out,
    output logic                     setbits_oe,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail
`ifdef GPIO_SEQ_TSTAMP_EN
    ,
    input  logic [$clog2(DEPTH)-1:0] ts_rd_addr,
    output logic [31:0]              ts_rd_data
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [SW-1:0] STABLE_TGT = SW'(STABLE_CYC);
    localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMO_SAT    = TW'(TIMEOUT_CYC);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_ACCEPT = 3'd2;
    localparam logic [2:0] ST_PASS   = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    typedef struct packed {
        logic        last;
        logic        drive_en;
        logic [13:0] drive_val;
        logic [6:0]  expect_st;
    } step_t;

    step_t         step_mem [DEPTH];
    step_t         cur_step;
    logic          status_match;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] step_idx_q, step_idx_d;
    logic [SW-1:0] stable_cnt_q, stable_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [13:0]   setbits_q, setbits_d;
    logic          setbits_oe_q, setbits_oe_d;
    logic          busy_q, busy_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic [6:0]    status_q, status_d;

    // Only the firmware status field is observed; the rest of the pad bus is ignored.
    logic          pads_unused;
    assign pads_unused = ^{mprj_io_in[37:32], mprj_io_in[24:0]};

    assign status_d = mprj_io_in[31:25];

    // NOTE: the step table is plain storage with no reset; firmware programs it before use,
    // and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clock) begin
        if (prog_we) begin
            step_mem[prog_addr] <= step_t'(prog_data);
        end
    end

    assign cur_step = step_mem[step_idx_q];

    // An X/Z status bit makes the equality unknown, which the if() in the FSM treats as no match.
    assign status_match = (status_q == cur_step.expect_st);

    // NOTE: every variable is given its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        step_idx_d   = step_idx_q;
        stable_cnt_d = stable_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        setbits_d    = setbits_q;
        setbits_oe_d = setbits_oe_q;
        busy_d       = busy_q;
        pass_d       = pass_q;
        fail_d       = fail_q;

        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    state_d      = ST_WAIT;
                    step_idx_d   = '0;
                    stable_cnt_d = '0;
                    tmo_cnt_d    = '0;
                    busy_d       = 1'b1;
                    pass_d       = 1'b0;
                    fail_d       = 1'b0;
                end
            end

            ST_WAIT: begin
                tmo_cnt_d    = (tmo_cnt_q == TMO_SAT) ? tmo_cnt_q : tmo_cnt_q + TW'(1);
                if (status_match) begin
                    stable_cnt_d = stable_cnt_q + SW'(1);
                end else begin
                    stable_cnt_d = '0;
                end
                // Accept is checked first so a match completing on the last allowed cycle wins.
                if (stable_cnt_q == STABLE_TGT) begin
                    state_d      = ST_ACCEPT;
                    stable_cnt_d = '0;
                    tmo_cnt_d    = '0;
                end else if (tmo_cnt_q >= TMO_LIMIT) begin
                    state_d      = ST_FAIL;
                    fail_d       = 1'b1;
                    busy_d       = 1'b0;
                    setbits_oe_d = 1'b0;
                end
            end

            ST_ACCEPT: begin
                if (cur_step.drive_en) begin
                    setbits_d    = cur_step.drive_val;
                    setbits_oe_d = 1'b1;
                end
                stable_cnt_d = '0;
                tmo_cnt_d    = '0;
                if (cur_step.last) begin
                    state_d = ST_PASS;
                    pass_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    // Past the last table entry the index wraps to 0 and the run continues.
                    step_idx_d = step_idx_q + AW'(1);
                    state_d    = ST_WAIT;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            step_idx_q   <= '0;
            stable_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            setbits_q    <= '0;
            setbits_oe_q <= 1'b0;
            busy_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            status_q     <= '0;
        end else begin
            state_q      <= state_d;
            step_idx_q   <= step_idx_d;
            stable_cnt_q <= stable_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            setbits_q    <= setbits_d;
            setbits_oe_q <= setbits_oe_d;
            busy_q       <= busy_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            status_q     <= status_d;
        end
    end

    assign setbits_out = setbits_q;
    assign setbits_oe  = setbits_oe_q;
    assign step_idx    = step_idx_q;
    assign busy        = busy_q;
    assign pass        = pass_q;
    assign fail        = fail_q;

`ifdef GPIO_SEQ_TSTAMP_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] ts_rd_q, ts_rd_d;
    logic [31:0] ts_mem [DEPTH];

    assign cyc_cnt_d = cyc_cnt_q + 32'd1;
    assign ts_rd_d   = ts_mem[ts_rd_addr];

    always_ff @(posedge clock) begin
        if (state_q == ST_ACCEPT) begin
            ts_mem[step_idx_q] <= cyc_cnt_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_cnt_q <= '0;
            ts_rd_q   <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            ts_rd_q   <= ts_rd_d;
        end
    end

    assign ts_rd_data = ts_rd_q;
`endif

endmodule

// File: tb/tb_gpio_seq_checker.sv
// Self-checking bench for gpio_seq_checker: vector table plus hand-written multi-cycle sequences,
// with expected outputs queued before each clock edge and compared just after it.
module tb_gpio_seq_checker;

    localparam int DEPTH       = 16;
    localparam int STABLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 100;

    typedef struct {
        string       name;
        logic [13:0] set;
        logic        oe;
        logic [3:0]  idx;
        logic        busy;
        logic        pass;
        logic        fail;
    } exp_t;

    typedef struct {
        logic [6:0]  status;
        logic [13:0] e_set;
        logic        e_oe;
        logic        e_busy;
        logic        e_pass;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [22:0] prog_data;
    logic [37:0] mprj_io_in;
    logic [13:0] setbits_out;
    logic        setbits_oe;
    logic [3:0]  step_idx;
    logic        busy;
    logic        pass;
    logic        fail;
`ifdef GPIO_SEQ_TSTAMP_EN
    logic [3:0]  ts_rd_addr;
    logic [31:0] ts_rd_data;
    logic [31:0] ts_v [3];
`endif

    logic [6:0]  status_v;
    exp_t        sb_q [$];
    int          checks = 0;
    int          errors = 0;

    vec_t        gl [12];
    logic [6:0]  fw_exp [3];
    logic [13:0] fw_drv [3];

    gpio_seq_checker #(
        .DEPTH      (DEPTH),
        .STABLE_CYC (STABLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .mprj_io_in (mprj_io_in),
        .setbits_out(setbits_out),
        .setbits_oe (setbits_oe),
        .step_idx   (step_idx),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail)
`ifdef GPIO_SEQ_TSTAMP_EN
        ,
        .ts_rd_addr (ts_rd_addr),
        .ts_rd_data (ts_rd_data)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic compare(input exp_t e);
        check({e.name, " {set,oe,idx,busy,pass,fail}"},
              {10'd0, setbits_out, setbits_oe, step_idx, busy, pass, fail},
              {10'd0, e.set, e.oe, e.idx, e.busy, e.pass, e.fail});
    endtask

    task automatic expect_out(input string name, input logic [13:0] set, input logic oe,
                              input logic [3:0] idx, input logic b, input logic p, input logic f);
        exp_t e;
        e.name = name;
        e.set  = set;
        e.oe   = oe;
        e.idx  = idx;
        e.busy = b;
        e.pass = p;
        e.fail = f;
        sb_q.push_back(e);
    endtask

    // One clock: drive pads (status plus noise on unrelated bits), take the edge, score queued expectations.
    task automatic clk1();
        mprj_io_in = {6'($urandom), status_v, 25'($urandom)};
        @(posedge clock);
        #1;
        while (sb_q.size() > 0) begin
            compare(sb_q.pop_front());
        end
        @(negedge clock);
    endtask

    task automatic prog(input logic [3:0] a, input logic last, input logic den,
                        input logic [13:0] val, input logic [6:0] ex);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = {last, den, val, ex};
        clk1();
        prog_we   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 12; i++) begin
            gl[i].status = (i < 3 || (i >= 5 && i <= 8)) ? 7'h20 : 7'h00;
            gl[i].e_set  = (i == 11) ? 14'h1234 : 14'h0000;
            gl[i].e_oe   = (i == 11);
            gl[i].e_busy = (i != 11);
            gl[i].e_pass = (i == 11);
        end
        fw_exp[0] = 7'h20; fw_drv[0] = 14'h00F0;
        fw_exp[1] = 7'h0B; fw_drv[1] = 14'h000F;
        fw_exp[2] = 7'h2B; fw_drv[2] = 14'h0000;

        reset     = 1'b1;
        start     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        status_v  = 7'h00;
`ifdef GPIO_SEQ_TSTAMP_EN
        ts_rd_addr = '0;
`endif
        clk1();
        expect_out("reset", 14'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        clk1();
`ifdef GPIO_SEQ_TSTAMP_EN
        check("ts_reset", ts_rd_data, 32'd0);
`endif
        reset = 1'b0;

        // Firmware-style three-step run, each status held 10 cycles.
        for (int j = 0; j < 3; j++) begin
            prog(4'(j), (j == 2), 1'b1, fw_drv[j], fw_exp[j]);
        end
        status_v = 7'h00;
        start = 1'b1;
        expect_out("fw_start", 14'h0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        clk1();
        start = 1'b0;
        begin
            logic [13:0] prev_set;
            logic        prev_oe;
            prev_set = 14'h0;
            prev_oe  = 1'b0;
            for (int j = 0; j < 3; j++) begin
                status_v = fw_exp[j];
                for (int k = 1; k <= 10; k++) begin
                    if (k == 6)
                        expect_out($sformatf("fw_hold%0d", j), prev_set, prev_oe, 4'(j), 1'b1, 1'b0, 1'b0);
                    if (k == 7)
                        expect_out($sformatf("fw_drive%0d", j), fw_drv[j], 1'b1,
                                   (j == 2) ? 4'(j) : 4'(j + 1), (j != 2), (j == 2), 1'b0);
                    clk1();
                end
                prev_set = fw_drv[j];
                prev_oe  = 1'b1;
            end
        end
        expect_out("fw_final", 14'h0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
        clk1();

`ifdef GPIO_SEQ_TSTAMP_EN
        for (int a = 0; a < 3; a++) begin
            ts_rd_addr = 4'(a);
            clk1();
            ts_v[a] = ts_rd_data;
        end
        check("ts_diff_0_1", ts_v[1] - ts_v[0], 32'd10);
        check("ts_diff_1_2", ts_v[2] - ts_v[1], 32'd10);
`endif

        // Timeout: status never matches; fail lands exactly TIMEOUT_CYC cycles after start.
        prog(4'd0, 1'b1, 1'b1, 14'h3FFF, 7'h55);
        status_v = 7'h00;
        start = 1'b1;
        expect_out("to_start", 14'h0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        clk1();
        start = 1'b0;
        for (int k = 1; k <= TIMEOUT_CYC; k++) begin
            if (k == TIMEOUT_CYC - 1)
                expect_out("to_before", 14'h0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
            if (k == TIMEOUT_CYC)
                expect_out("to_fail", 14'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
            clk1();
        end

        // Glitch rejection, table-driven; reset first also clears the sticky fail.
        reset = 1'b1;
        expect_out("gl_reset", 14'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        clk1();
        reset = 1'b0;
        prog(4'd0, 1'b1, 1'b1, 14'h1234, 7'h20);
        status_v = 7'h00;
        start = 1'b1;
        expect_out("gl_start", 14'h0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        clk1();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            status_v = gl[i].status;
            expect_out($sformatf("glitch[%0d]", i), gl[i].e_set, gl[i].e_oe, 4'd0,
                       gl[i].e_busy, gl[i].e_pass, 1'b0);
            clk1();
        end

        // Match completing on the final timeout cycle: accept wins.
        prog(4'd0, 1'b1, 1'b1, 14'h2AAA, 7'h55);
        status_v = 7'h00;
        start = 1'b1;
        expect_out("sim_start", 14'h1234, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        clk1();
        start = 1'b0;
        for (int k = 1; k <= TIMEOUT_CYC + 1; k++) begin
            status_v = (k >= TIMEOUT_CYC - STABLE_CYC - 1) ? 7'h55 : 7'h00;
            if (k == TIMEOUT_CYC)
                expect_out("sim_accept", 14'h1234, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
            if (k == TIMEOUT_CYC + 1)
                expect_out("sim_pass", 14'h2AAA, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
            clk1();
        end

        // Same run with the match one cycle later: timeout fires.
        status_v = 7'h00;
        start = 1'b1;
        expect_out("late_start", 14'h2AAA, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        clk1();
        start = 1'b0;
        for (int k = 1; k <= TIMEOUT_CYC; k++) begin
            status_v = (k >= TIMEOUT_CYC - STABLE_CYC) ? 7'h55 : 7'h00;
            if (k == TIMEOUT_CYC)
                expect_out("late_fail", 14'h2AAA, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
            clk1();
        end

        // Reset mid step 1 while driving 00F0, then rerun from step 0.
        prog(4'd0, 1'b0, 1'b1, 14'h00F0, 7'h20);
        status_v = 7'h00;
        start = 1'b1;
        expect_out("rm_start", 14'h2AAA, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        clk1();
        start = 1'b0;
        status_v = 7'h20;
        for (int k = 1; k <= 8; k++) begin
            if (k == 7)
                expect_out("rm_drive", 14'h00F0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
            clk1();
        end
        reset = 1'b1;
        expect_out("rm_reset", 14'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        clk1();
        reset = 1'b0;
        status_v = 7'h00;
        start = 1'b1;
        expect_out("rm_restart", 14'h0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        clk1();
        start = 1'b0;
        status_v = 7'h20;
        for (int k = 1; k <= 7; k++) begin
            if (k == 7)
                expect_out("rm_rerun", 14'h00F0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
            clk1();
        end

        // Wrap through all 16 steps, start ignored while busy, then a write to the live step.
        reset = 1'b1;
        clk1();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            prog(4'(i), 1'b0, (i == DEPTH - 1), 14'h0F00 + 14'(i), 7'h40 + 7'(i));
        end
        status_v = 7'h00;
        start = 1'b1;
        clk1();
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            status_v = 7'h40 + 7'(i);
            for (int k = 1; k <= 7; k++) begin
                start = (i == 8 && k == 3);
                if (k == 7)
                    expect_out($sformatf("wrap_step%0d", i), (i == DEPTH - 1) ? 14'h0F0F : 14'h0000,
                               (i == DEPTH - 1), 4'(i + 1), 1'b1, 1'b0, 1'b0);
                clk1();
            end
        end
        start = 1'b0;
        prog(4'd0, 1'b1, 1'b1, 14'h1111, 7'h40);
        status_v = 7'h40;
        for (int k = 1; k <= 7; k++) begin
            if (k == 7)
                expect_out("wrap_last", 14'h1111, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
            clk1();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
